psum_acc_wb: RTL and testbench

PSUM_ACC_WB -- requirements
Module: psum_acc_wb

---
 rtl/psum_acc_wb_pkg.sv | 16 +
 rtl/psum_acc_wb_if.sv | 36 +++
 rtl/psum_lane.sv | 28 ++
 rtl/psum_acc_wb.sv | 103 ++++++++++
 tb/tb_psum_acc_wb.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_acc_wb_pkg.sv
// Shared definitions for the psum accumulate/write-back block:
// FSM state encoding and default geometry.
package psum_acc_wb_pkg;

    localparam int COL_DEFAULT     = 8;
    localparam int PSUM_BW_DEFAULT = 16;
    localparam int ADDR_BW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/psum_acc_wb_if.sv
// Pass control, output-FIFO and psum-SRAM signals of the accumulator.
// master = accumulator side, slave = surrounding system.
interface psum_acc_wb_if
    import psum_acc_wb_pkg::*;
#(
    parameter int col     = COL_DEFAULT,
    parameter int psum_bw = PSUM_BW_DEFAULT,
    parameter int addr_bw = ADDR_BW_DEFAULT
) ();

    logic                     start;
    logic [addr_bw-1:0]       num_vec;
    logic                     first_pass;
    logic                     last_pass;
    logic                     ofifo_valid;
    logic [psum_bw*col-1:0]   ofifo_data;
    logic                     ofifo_rd;
    logic [psum_bw*col-1:0]   sram_q;
    logic                     sram_cen;
    logic                     sram_wen;
    logic [addr_bw-1:0]       sram_addr;
    logic [psum_bw*col-1:0]   sram_d;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, num_vec, first_pass, last_pass, ofifo_valid, ofifo_data, sram_q,
        output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );

    modport slave (
        output start, num_vec, first_pass, last_pass, ofifo_valid, ofifo_data, sram_q,
        input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
    );

endinterface

// File: rtl/psum_lane.sv
// One psum lane: signed add with one guard bit, saturation to psum_bw,
// then optional ReLU. Purely combinational.
module psum_lane
    import psum_acc_wb_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEFAULT
) (
    input  logic [psum_bw-1:0] a,
    input  logic [psum_bw-1:0] b,
    input  logic               relu_en,
    output logic [psum_bw-1:0] y
);

    logic [psum_bw:0]   sum;
    logic [psum_bw-1:0] sat;

    always_comb begin
        sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        // Overflow shows as a disagreement between the guard bit and the lane sign bit.
        if (sum[psum_bw] != sum[psum_bw-1]) begin
            sat = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end else begin
            sat = sum[psum_bw-1:0];
        end
        y = (relu_en && sat[psum_bw-1]) ? '0 : sat;
    end

endmodule

// File: rtl/psum_acc_wb.sv
// Pops psum vectors from the output FIFO, adds the matching SRAM psums
// (or zero on a first pass), saturates / ReLUs, and writes them back.
module psum_acc_wb
    import psum_acc_wb_pkg::*;
#(
    parameter int col     = COL_DEFAULT,
    parameter int psum_bw = PSUM_BW_DEFAULT,
    parameter int addr_bw = ADDR_BW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    psum_acc_wb_if.master      bus
);

    localparam int vec_bw = psum_bw * col;

    state_t             state, state_nxt;
    logic [addr_bw-1:0] cnt;
    logic [addr_bw-1:0] num_vec_q;
    logic               first_q;
    logic               last_q;
    logic [vec_bw-1:0]  data_q;
    logic [vec_bw-1:0]  addend;
    logic [vec_bw-1:0]  result;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: data_q is one register, not an array, so it is reset along with the control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            num_vec_q <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    cnt       <= '0;
                    num_vec_q <= bus.num_vec;
                    first_q   <= bus.first_pass;
                    last_q    <= bus.last_pass;
                end
                RD:   if (bus.ofifo_valid) data_q <= bus.ofifo_data;
                // Compare before incrementing so the last address never wraps.
                ACC:  if (cnt != num_vec_q) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.ofifo_rd  = 1'b0;
        bus.sram_cen  = 1'b1;
        bus.sram_wen  = 1'b1;
        bus.sram_addr = '0;
        bus.sram_d    = '0;
        bus.busy      = (state != IDLE);
        bus.done      = 1'b0;
        unique case (state)
            IDLE: if (bus.start) state_nxt = RD;
            RD: begin
                bus.sram_addr = cnt;
                if (bus.ofifo_valid) begin
                    bus.ofifo_rd = 1'b1;
                    bus.sram_cen = first_q;
                    state_nxt    = ACC;
                end
            end
            ACC: begin
                bus.sram_cen  = 1'b0;
                bus.sram_wen  = 1'b0;
                bus.sram_addr = cnt;
                bus.sram_d    = result;
                state_nxt     = (cnt == num_vec_q) ? DONE : RD;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // No SRAM read was issued on a first pass, so sram_q is meaningless there.
    assign addend = first_q ? '0 : bus.sram_q;

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_lane #(.psum_bw(psum_bw)) u_lane (
            .a       (data_q[i*psum_bw +: psum_bw]),
            .b       (addend[i*psum_bw +: psum_bw]),
            .relu_en (last_q),
            .y       (result[i*psum_bw +: psum_bw])
        );
    end

endmodule

// File: tb/tb_psum_acc_wb.sv
// Self-checking bench for psum_acc_wb: SRAM and FIFO models plus a
// lane-arithmetic reference model of the expected SRAM contents.
module tb_psum_acc_wb;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int AW    = 4;
    localparam int VW    = COL * BW;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    psum_acc_wb_if #(.col(COL), .psum_bw(BW), .addr_bw(AW)) bus ();

    psum_acc_wb #(.col(COL), .psum_bw(BW), .addr_bw(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] mem [DEPTH] = '{default: '0};
    logic [VW-1:0] ref_mem [DEPTH] = '{default: '0};
    logic [VW-1:0] q_r = '0;
    logic [VW-1:0] fifo [$];
    logic [VW-1:0] stim [$];
    int            wr_log [$];
    int            rd_cnt = 0;
    int            pop_cnt = 0;
    int            done_cnt = 0;
    int            viol = 0;
    int            stall_cyc = 0;
    int            stall_bad = 0;
    bit            hold = 1'b0;

    assign bus.sram_q = q_r;

    // SRAM and FIFO pop model
    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_wen) begin
                mem[bus.sram_addr] <= bus.sram_d;
                wr_log.push_back(int'(bus.sram_addr));
            end else begin
                q_r    <= mem[bus.sram_addr];
                rd_cnt <= rd_cnt + 1;
            end
        end
        if (bus.ofifo_rd && fifo.size() > 0) begin
            void'(fifo.pop_front());
            pop_cnt <= pop_cnt + 1;
        end
    end

    initial forever begin
        @(negedge clk);
        bus.ofifo_valid = (fifo.size() > 0) && !hold;
        bus.ofifo_data  = (fifo.size() > 0) ? fifo[0] : '0;
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (bus.done) done_cnt++;
        if (!bus.busy && (bus.ofifo_rd || !bus.sram_cen || !bus.sram_wen)) viol++;
        if (bus.ofifo_rd && !bus.ofifo_valid) viol++;
        if (bus.busy && !bus.ofifo_valid && fifo.size() > 0) begin
            stall_cyc++;
            if (bus.ofifo_rd || !bus.sram_cen || bus.done) stall_bad++;
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] ref_sum(input logic [VW-1:0] old_v, input logic [VW-1:0] vec,
                                              input bit first, input bit last);
        logic [VW-1:0] r;
        logic [BW-1:0] la, lb;
        int a, b, s;
        for (int i = 0; i < COL; i++) begin
            la = old_v[i*BW +: BW];
            lb = vec[i*BW +: BW];
            a  = first ? 0 : int'($signed(la));
            b  = int'($signed(lb));
            s  = a + b;
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            if (last && s < 0) s = 0;
            r[i*BW +: BW] = s[BW-1:0];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_stim(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(rand_vec());
    endtask

    task automatic run_pass(input int nv, input bit first, input bit last, input bit chk_lat, input bit poke);
        int  rd0, wr0, dn0, k;
        bit  seen;
        for (int i = 0; i <= nv; i++) begin
            fifo.push_back(stim[i]);
            ref_mem[i] = ref_sum(ref_mem[i], stim[i], first, last);
        end
        rd0 = rd_cnt;
        wr0 = wr_log.size();
        dn0 = done_cnt;
        repeat (2) @(negedge clk);
        bus.num_vec    = nv[AW-1:0];
        bus.first_pass = first;
        bus.last_pass  = last;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.num_vec    = ~nv[AW-1:0];
        bus.first_pass = !first;
        bus.last_pass  = !last;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 200) begin
            if (k > 0) @(negedge clk);
            k++;
            #1 seen = bus.done;
            if (poke && k == 3) begin
                bus.start   = 1'b1;
                bus.num_vec = '0;
            end
            if (poke && k == 4) bus.start = 1'b0;
        end
        if (poke && seen) begin
            bus.start   = 1'b1;
            bus.num_vec = '1;
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("done_seen", seen, 1);
        if (chk_lat) check("latency", k, 2 * nv + 3);
        check("done_count", done_cnt - dn0, 1);
        check("idle_after", bus.busy, 0);
        check("sram_reads", rd_cnt - rd0, first ? 0 : nv + 1);
        check("sram_writes", wr_log.size() - wr0, nv + 1);
        for (int i = 0; i <= nv; i++) begin
            if (wr0 + i < wr_log.size()) check("write_order", wr_log[wr0 + i], i);
            check("mem_word", mem[i], ref_mem[i]);
        end
    endtask

    initial begin
        int p0, sc0, sb0, wr0, t;
        bit hit;
        bus.start      = 1'b0;
        bus.num_vec    = '0;
        bus.first_pass = 1'b0;
        bus.last_pass  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_cen", bus.sram_cen, 1);
        check("rst_wen", bus.sram_wen, 1);
        check("rst_rd", bus.ofifo_rd, 0);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_d", bus.sram_d, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b1;

        // First pass: plain copy, no reads, fixed latency
        stim.delete();
        stim.push_back({COL{16'd5}});
        stim.push_back({COL{16'd6}});
        stim.push_back({COL{16'd7}});
        run_pass(2, 1'b1, 1'b0, 1'b1, 1'b0);
        check("copy_a0", mem[0], {COL{16'd5}});
        check("copy_a2", mem[2], {COL{16'd7}});

        // Saturation in both directions
        stim.delete();
        stim.push_back({{4{16'h8008}}, {4{16'd32760}}});
        run_pass(0, 1'b1, 1'b0, 1'b0, 1'b0);
        stim.delete();
        stim.push_back({{4{16'hFF9C}}, {4{16'd100}}});
        run_pass(0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("saturate", mem[0], {{4{16'h8000}}, {4{16'h7FFF}}});

        // ReLU on the last pass
        stim.delete();
        stim.push_back({{4{16'd20}}, {4{16'hFFEC}}});
        run_pass(0, 1'b1, 1'b0, 1'b0, 1'b0);
        stim.delete();
        stim.push_back({COL{16'd5}});
        run_pass(0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("relu", mem[0], {{4{16'd25}}, {4{16'd0}}});

        // Randomized passes, with ignored start pulses on odd rounds
        for (int r = 0; r < 6; r++) begin
            int nv;
            nv = $urandom_range(3, 7);
            rand_stim(nv + 1);
            run_pass(nv, (r == 0), ($urandom_range(0, 2) == 0), 1'b1, r[0]);
        end

        // Full-depth passes: last address is 2^addr_bw-1
        rand_stim(DEPTH);
        run_pass(DEPTH - 1, 1'b0, 1'b0, 1'b1, 1'b0);
        rand_stim(DEPTH);
        run_pass(DEPTH - 1, 1'b0, 1'b1, 1'b1, 1'b1);

        // FIFO empty for 4 cycles in the middle of a pass
        rand_stim(4);
        p0  = pop_cnt;
        sc0 = stall_cyc;
        sb0 = stall_bad;
        fork
            run_pass(3, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 100 && pop_cnt < p0 + 2; i++) @(negedge clk);
                #2 hold = 1'b1;
                repeat (4) @(negedge clk);
                #2 hold = 1'b0;
            end
        join
        check("stall_cycles", stall_cyc - sc0, 4);
        check("stall_quiet", stall_bad - sb0, 0);

        // Reset in the middle of a pass, during a write
        rand_stim(4);
        for (int i = 0; i < 4; i++) fifo.push_back(stim[i]);
        repeat (2) @(negedge clk);
        bus.num_vec    = 4'd3;
        bus.first_pass = 1'b1;
        bus.last_pass  = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        hit = 1'b0;
        t   = 0;
        while (!hit && t < 50) begin
            if (t > 0) @(negedge clk);
            t++;
            #1 hit = !bus.sram_cen && !bus.sram_wen && (bus.sram_addr == 4'd1);
        end
        check("reached_acc", hit, 1);
        reset = 1'b0;
        #1;
        check("midrst_cen", bus.sram_cen, 1);
        check("midrst_wen", bus.sram_wen, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_addr", bus.sram_addr, 0);
        check("midrst_d", bus.sram_d, 0);
        fifo.delete();
        wr0 = wr_log.size();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("no_resume", wr_log.size() - wr0, 0);
        check("idle_after_rst", bus.busy, 0);

        // Restart from address 0 and resynchronise every SRAM word
        rand_stim(DEPTH);
        run_pass(DEPTH - 1, 1'b1, 1'b0, 1'b1, 1'b0);

        check("protocol", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
